key_debouncer: RTL and testbench

- Upstream conditioning stage for the push-button inputs that drive the LED flasher speed/reset controls.
- Synchronises raw active-low board keys, debounces each key independently, and emits a clean held level plus one-cycle press and release strobes.
- Downstream logic consumes these strobes directly, replacing ad hoc click/unclick tracking.
- Optional auto-repeat lets a held key generate repeated press strobes.

---
 rtl/key_debouncer.sv | 188 ++++++++++++++++++
 tb/tb_key_debouncer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//
// Conditions raw active-low push-button inputs for downstream control logic.
// Each key goes through a two-flop synchroniser and then an independent
// debouncer. The debouncer holds a stable level and a pending count. A key
// produces a clean held level and one-cycle press and release strobes.
//
// Optional build macro:
//   KEY_DEBOUNCER_AUTOREPEAT_EN - a held key re-issues KEY_PRESS strobes.
//                                 The first repeat comes REPEAT_DELAY cycles
//                                 after the accepted press. Later repeats
//                                 come every REPEAT_PERIOD cycles.
//
// Parameters:
//   NUM_KEYS        number of independent keys (>= 1)
//   DEBOUNCE_CYCLES consecutive cycles a new level must persist (>= 2)
//   REPEAT_DELAY    press-to-first-repeat distance (auto-repeat builds only)
//   REPEAT_PERIOD   repeat-to-repeat distance (auto-repeat builds only)
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   KEY          in   raw keys, active-low, asynchronous to CLOCK_50
//   KEY_DOWN     out  debounced level, 1 = pressed
//   KEY_PRESS    out  one-cycle strobe per accepted press (and per repeat)
//   KEY_RELEASE  out  one-cycle strobe per accepted release
//
// Handshake: there is none. The strobes are single-cycle pulses with no ready
// or back-pressure. A consumer must sample them on every rising edge.
// -----------------------------------------------------------------------------
module key_debouncer #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 12500000
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] KEY_DOWN,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE
);

    // The stable state of each key. A pending change lives in the counter,
    // not in a separate state.
    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } key_state_t;

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (NUM_KEYS < 1 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_debouncer: illegal parameter value");
    end

    // Synchroniser. Both flops reset to 1, which is the released level.
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] ksync_q;
    logic [NUM_KEYS-1:0] ksync_pressed;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '1;
            ksync_q <= '1;
        end else begin
            sync1_q <= KEY;
            ksync_q <= sync1_q;
        end
    end

    assign ksync_pressed = ~ksync_q;

    // Debounce state
    key_state_t          state_q [NUM_KEYS];
    key_state_t          state_d [NUM_KEYS];
    logic [CW-1:0]       cnt_q   [NUM_KEYS];
    logic [CW-1:0]       cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0] press_q;
    logic [NUM_KEYS-1:0] press_d;
    logic [NUM_KEYS-1:0] release_q;
    logic [NUM_KEYS-1:0] release_d;

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int            RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW      = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    // rep_armed marks that the first repeat has already gone out.
    // After that point the shorter period applies.
    logic [RW-1:0]       rep_cnt_q [NUM_KEYS];
    logic [RW-1:0]       rep_cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] rep_armed_q;
    logic [NUM_KEYS-1:0] rep_armed_d;
`endif

    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k]   = state_q[k];
            cnt_d[k]     = '0;
            press_d[k]   = 1'b0;
            release_d[k] = 1'b0;

            // A sample that matches the stable level restarts the count.
            // This is how bounce gets rejected.
            if (ksync_pressed[k] == (state_q[k] == PRESSED)) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == DB_LAST) begin
                if (ksync_pressed[k]) begin
                    state_d[k] = PRESSED;
                    press_d[k] = 1'b1;
                end else begin
                    state_d[k]   = RELEASED;
                    release_d[k] = 1'b1;
                end
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
            rep_cnt_d[k]   = '0;
            rep_armed_d[k] = 1'b0;
            // Repeats run only while the key is stably held. The release
            // cycle itself is excluded. The counter is zero on the edge that
            // accepts a press, so distances are measured from that strobe.
            if (state_q[k] == PRESSED && !release_d[k]) begin
                if (rep_cnt_q[k] == (rep_armed_q[k] ? RP_LAST : RD_LAST)) begin
                    press_d[k]     = 1'b1;
                    rep_armed_d[k] = 1'b1;
                end else begin
                    rep_cnt_d[k]   = rep_cnt_q[k] + 1'b1;
                    rep_armed_d[k] = rep_armed_q[k];
                end
            end
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= RELEASED;
                cnt_q[k]   <= '0;
            end
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                rep_cnt_q[k] <= '0;
            end
            rep_armed_q <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                rep_cnt_q[k] <= rep_cnt_d[k];
            end
            rep_armed_q <= rep_armed_d;
        end
    end
`endif

    // KEY_DOWN is the stable state itself. It changes on the same edge as
    // the registered strobe.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            KEY_DOWN[k] = (state_q[k] == PRESSED);
        end
    end

    assign KEY_PRESS   = press_q;
    assign KEY_RELEASE = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
//
// Drives directed key patterns into key_debouncer.
//
// A behavioural model tracks the expected outputs. The model keeps the history
// of raw key samples. The debouncer sees each sample two edges late. A level
// is accepted once the last DEBOUNCE_CYCLES seen samples all disagree with the
// current level. Repeat strobes come from the distance to the accepted press.
//
// A compare process checks the DUT against the model on every falling edge.
// Directed steps also check literal values, which pins down the model.
// -----------------------------------------------------------------------------
module tb_key_debouncer;

    localparam int NUM_KEYS = 3;
    localparam int DC       = 4;
    localparam int RD       = 10;
    localparam int RP       = 3;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic [NUM_KEYS-1:0] key;
    logic [NUM_KEYS-1:0] key_down;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    key_debouncer #(
        .NUM_KEYS       (NUM_KEYS),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .KEY        (key),
        .KEY_DOWN   (key_down),
        .KEY_PRESS  (key_press),
        .KEY_RELEASE(key_release)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got no end, expected end");
        $fatal(1, "timeout");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [NUM_KEYS-1:0] got,
                         input logic [NUM_KEYS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NUM_KEYS-1:0] exp_down;
    logic [NUM_KEYS-1:0] exp_press;
    logic [NUM_KEYS-1:0] exp_release;
    logic [NUM_KEYS-1:0] raw_hist[$];   // raw_hist[i] = KEY sampled at post-reset edge i+1
    int                  press_edge [NUM_KEYS];

    initial begin
        exp_down    = '0;
        exp_press   = '0;
        exp_release = '0;
        for (int k = 0; k < NUM_KEYS; k++) press_edge[k] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                raw_hist.delete();
                exp_down    = '0;
                exp_press   = '0;
                exp_release = '0;
            end else begin
                int n;
                raw_hist.push_back(key);
                n = raw_hist.size();
                exp_press   = '0;
                exp_release = '0;
                for (int k = 0; k < NUM_KEYS; k++) begin
                    bit all_differ;
                    all_differ = 1'b1;
                    // Edge m sees the raw sample of edge m-2. Before that
                    // sample exists, the released level is seen.
                    for (int m = n - DC + 1; m <= n; m++) begin
                        logic seen_raw;
                        seen_raw = (m >= 3) ? raw_hist[m-3][k] : 1'b1;
                        if ((!seen_raw) == exp_down[k]) all_differ = 1'b0;
                    end
                    if (all_differ) begin
                        exp_down[k] = ~exp_down[k];
                        if (exp_down[k]) begin
                            exp_press[k]  = 1'b1;
                            press_edge[k] = n;
                        end else begin
                            exp_release[k] = 1'b1;
                        end
                    end else if (AR && exp_down[k]) begin
                        int t;
                        t = n - press_edge[k];
                        if (t == RD || (t > RD && (t - RD) % RP == 0)) exp_press[k] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("cyc_down",    key_down,    exp_down);
                check("cyc_press",   key_press,   exp_press);
                check("cyc_release", key_release, exp_release);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Every step ends 1 ns after a rising edge. Inputs change there, and
    // literal checks read there.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [NUM_KEYS-1:0] d,
                             input logic [NUM_KEYS-1:0] p, input logic [NUM_KEYS-1:0] r);
        check({name, "_down"},    key_down,    d);
        check({name, "_press"},   key_press,   p);
        check({name, "_release"}, key_release, r);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [NUM_KEYS-1:0] ar_exp;
        rst_n = 1'b0;
        key   = '1;
        tick(3);
        cmp_en = 1'b1;
        check_out("reset", 3'b000, 3'b000, 3'b000);

        // Idle after reset: nothing may move.
        rst_n = 1'b1;
        tick(20);
        check_out("idle", 3'b000, 3'b000, 3'b000);
        check("idle_model_down", exp_down, 3'b000);

        // Clean press and release of key 0.
        key = 3'b110;
        tick(5);
        check_out("k0_edge5", 3'b000, 3'b000, 3'b000);
        tick(1);
        check_out("k0_edge6", 3'b001, 3'b001, 3'b000);
        check("k0_edge6_model_press", exp_press, 3'b001);
        tick(1);
        check_out("k0_edge7", 3'b001, 3'b000, 3'b000);
        key = 3'b111;
        tick(5);
        check_out("k0_rel_edge5", 3'b001, 3'b000, 3'b000);
        tick(1);
        check_out("k0_rel_edge6", 3'b000, 3'b000, 3'b001);
        check("k0_rel_model_release", exp_release, 3'b001);
        tick(1);
        check_out("k0_rel_edge7", 3'b000, 3'b000, 3'b000);
        tick(5);

        // Key 1 bounces 0,1,0,1 and then settles at 0.
        for (int i = 0; i < 4; i++) begin
            key[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
            check("bounce_press", key_press, 3'b000);
        end
        key[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("settle_press", key_press, 3'b000);
        end
        tick(1);
        check_out("settle_edge6", 3'b010, 3'b010, 3'b000);
        key = 3'b111;
        tick(6);
        check_out("k1_release", 3'b000, 3'b000, 3'b010);
        tick(4);

        // A 3-cycle low glitch on key 1 is shorter than the debounce window.
        key = 3'b101;
        tick(3);
        key = 3'b111;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_out("glitch", 3'b000, 3'b000, 3'b000);
        end

        // Keys 0 and 2 pressed together, then key 2 released alone. The key 0
        // release lands 13 edges after its press. An auto-repeat strobe due on
        // that same edge must be suppressed.
        key = 3'b010;
        tick(6);
        check_out("dual_press", 3'b101, 3'b101, 3'b000);
        tick(1);
        check_out("dual_after", 3'b101, 3'b000, 3'b000);
        key = 3'b110;
        tick(6);
        check_out("k2_release", 3'b001, 3'b000, 3'b100);
        key = 3'b111;
        tick(6);
        check_out("k0_release", 3'b000, 3'b000, 3'b001);
        tick(5);

        // Reset arrives while key 1 is mid-count (counter = 2 after edge 4).
        key = 3'b101;
        tick(4);
        check_out("pre_reset", 3'b000, 3'b000, 3'b000);
        rst_n = 1'b0;
        tick(2);
        check_out("in_reset", 3'b000, 3'b000, 3'b000);
        rst_n = 1'b1;
        tick(5);
        check_out("post_reset_edge5", 3'b000, 3'b000, 3'b000);
        tick(1);
        check_out("post_reset_edge6", 3'b010, 3'b010, 3'b000);
        key = 3'b111;
        tick(6);
        check_out("post_reset_release", 3'b000, 3'b000, 3'b010);
        tick(5);

        // Hold key 0. Repeats at P+10, P+13, P+16 only in auto-repeat builds.
        ar_exp = AR ? 3'b001 : 3'b000;
        key = 3'b110;
        tick(6);
        check_out("hold_P", 3'b001, 3'b001, 3'b000);
        tick(9);
        check_out("hold_P9", 3'b001, 3'b000, 3'b000);
        tick(1);
        check_out("hold_P10", 3'b001, ar_exp, 3'b000);
        check("hold_P10_model", exp_press, ar_exp);
        tick(1);
        check_out("hold_P11", 3'b001, 3'b000, 3'b000);
        tick(2);
        check_out("hold_P13", 3'b001, ar_exp, 3'b000);
        tick(3);
        check_out("hold_P16", 3'b001, ar_exp, 3'b000);
        // The release lands at P+22, which would also be a repeat edge.
        key = 3'b111;
        tick(6);
        check_out("hold_release", 3'b000, 3'b000, 3'b001);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_out("after_hold", 3'b000, 3'b000, 3'b000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
